// File: rtl/cabac_bs_pkg.sv
// Shared types and defaults for the CABAC bitstream packer.
package cabac_bs_pkg;

    localparam int DEF_WORD_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_BIN_W  = 8;
    localparam int NUM_W      = 4;

    localparam logic CEN_ON = 1'b0;
    localparam logic WEN_ON = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } bs_state_t;

endpackage

// File: rtl/cabac_bs_shifter.sv
// Merges a right-aligned chunk into the MSB-first accumulator and extracts a full word.
// Latency: combinational. Backpressure: none, at most one word per call.
module cabac_bs_shifter
    import cabac_bs_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int BIN_W  = DEF_BIN_W,
    parameter int ACC_W  = WORD_W + BIN_W,
    parameter int CNT_W  = $clog2(WORD_W + BIN_W + 1)
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              val,
    input  logic [NUM_W-1:0]  num,
    input  logic [BIN_W-1:0]  dat,
    output logic [ACC_W-1:0]  acc_nxt,
    output logic [CNT_W-1:0]  cnt_nxt,
    output logic [WORD_W-1:0] word,
    output logic              word_vld
);

    localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
    localparam logic [NUM_W-1:0] BIN_C  = NUM_W'(BIN_W);

    logic [BIN_W-1:0] mask;
    logic [ACC_W-1:0] acc_m;
    logic [CNT_W-1:0] cnt_m;

    always_comb begin
        acc_nxt  = acc;
        cnt_nxt  = cnt;
        word     = '0;
        word_vld = 1'b0;
        mask     = ~({BIN_W{1'b1}} << num);
        acc_m    = (acc << num) | ACC_W'(dat & mask);
        cnt_m    = cnt + CNT_W'(num);
        // Zero-length or oversize chunks leave the accumulator untouched.
        if (val && (num != '0) && (num <= BIN_C)) begin
            acc_nxt = acc_m;
            if (cnt_m >= WORD_C) begin
                word     = WORD_W'(acc_m >> (cnt_m - WORD_C));
                word_vld = 1'b1;
                cnt_nxt  = cnt_m - WORD_C;
            end else begin
                cnt_nxt  = cnt_m;
            end
        end
    end

endmodule

// File: rtl/cabac_bs_pack.sv
// Packs 1..BIN_W-bit chunks MSB-first into WORD_W-bit SRAM words, flushes and reports the count.
// Latency: write strobe one cycle after the completing chunk. Backpressure: none, words past capacity are dropped (ovf_o).
// Option CABAC_BS_RBSP_TRAIL_EN: flush appends the rbsp stop bit before zero padding.
module cabac_bs_pack
    import cabac_bs_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              bits_val_i,
    input  logic [NUM_W-1:0]  bits_num_i,
    input  logic [BIN_W-1:0]  bits_dat_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              ovf_o,
    output logic              cen_o,
    output logic              oen_o,
    output logic              wen_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [WORD_W-1:0] data_o
);

    localparam int ACC_W = WORD_W + BIN_W;
    localparam int CNT_W = $clog2(WORD_W + BIN_W + 1);

    bs_state_t         state_q, state_nxt;
    logic [ACC_W-1:0]  acc_q, acc_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [ADDR_W:0]   word_cnt_q;
    logic [WORD_W-1:0] sh_word, flush_word, flush_bits, wr_word;
    logic              sh_word_vld, shift_en, flush_need, wr_req;

    cabac_bs_shifter #(
        .WORD_W (WORD_W),
        .BIN_W  (BIN_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_shifter (
        .acc      (acc_q),
        .cnt      (cnt_q),
        .val      (shift_en),
        .num      (bits_num_i),
        .dat      (bits_dat_i),
        .acc_nxt  (acc_nxt),
        .cnt_nxt  (cnt_nxt),
        .word     (sh_word),
        .word_vld (sh_word_vld)
    );

    // Live bits sit in acc_q[cnt_q-1:0]; shifting them to the top left-justifies and zero-pads.
`ifdef CABAC_BS_RBSP_TRAIL_EN
    assign flush_bits = {acc_q[WORD_W-2:0], 1'b1};
    assign flush_word = flush_bits << (CNT_W'(WORD_W - 1) - cnt_q);
    assign flush_need = 1'b1;
`else
    assign flush_bits = acc_q[WORD_W-1:0];
    assign flush_word = flush_bits << (CNT_W'(WORD_W) - cnt_q);
    assign flush_need = (cnt_q != '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        shift_en  = 1'b0;
        wr_req    = 1'b0;
        wr_word   = sh_word;
        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                shift_en = bits_val_i;
                wr_req   = sh_word_vld;
                if (flush_i) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                wr_req    = flush_need;
                wr_word   = flush_word;
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (start_i) begin
            state_nxt = S_RUN;
            shift_en  = 1'b0;
            wr_req    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            word_cnt_q <= '0;
            ovf_o      <= 1'b0;
            cen_o      <= ~CEN_ON;
            wen_o      <= ~WEN_ON;
            addr_o     <= '0;
            data_o     <= '0;
        end else begin
            cen_o <= ~CEN_ON;
            wen_o <= ~WEN_ON;
            if (start_i) begin
                acc_q      <= '0;
                cnt_q      <= '0;
                word_cnt_q <= '0;
                ovf_o      <= 1'b0;
            end else if (state_q == S_FLUSH) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_nxt;
                cnt_q <= cnt_nxt;
            end
            // Count MSB set means the SRAM is full; the count saturates there.
            if (wr_req) begin
                if (word_cnt_q[ADDR_W]) begin
                    ovf_o <= 1'b1;
                end else begin
                    cen_o      <= CEN_ON;
                    wen_o      <= WEN_ON;
                    addr_o     <= word_cnt_q[ADDR_W-1:0];
                    data_o     <= wr_word;
                    word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign busy_o     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done_o     = (state_q == S_DONE);
    assign word_cnt_o = word_cnt_q;
    assign oen_o      = 1'b1;

endmodule

// File: tb/tb_cabac_bs_pack.sv
// Directed bench for cabac_bs_pack: slice vector table plus reset and restart sequences.
module tb_cabac_bs_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, bits_val_i, flush_i;
    logic [3:0]  bits_num_i;
    logic [7:0]  bits_dat_i;
    logic        busy_o, done_o, ovf_o, cen_o, oen_o, wen_o;
    logic [8:0]  word_cnt_o;
    logic [7:0]  addr_o;
    logic [15:0] data_o;

    int checks = 0;
    int failures = 0;
    logic [23:0] wq[$];

    cabac_bs_pack dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .bits_val_i (bits_val_i),
        .bits_num_i (bits_num_i),
        .bits_dat_i (bits_dat_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .word_cnt_o (word_cnt_o),
        .ovf_o      (ovf_o),
        .cen_o      (cen_o),
        .oen_o      (oen_o),
        .wen_o      (wen_o),
        .addr_o     (addr_o),
        .data_o     (data_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (cen_o === 1'b0 && wen_o === 1'b0) wq.push_back({addr_o, data_o});

    typedef struct {
        int          n1;
        logic [3:0]  num1;
        logic [7:0]  dat1;
        int          n2;
        logic [3:0]  num2;
        logic [7:0]  dat2;
        bit          flush_last;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        bit          exp_ovf;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_chunk(input logic [3:0] num, input logic [7:0] dat, input bit fl);
        bits_val_i = 1'b1;
        bits_num_i = num;
        bits_dat_i = dat;
        flush_i    = fl;
        tick();
        bits_val_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [8:0] exp_cnt, input bit exp_ovf);
        bit seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_word_cnt"}, 32'(word_cnt_o), 32'(exp_cnt));
        chk({name, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
        tick();
        chk({name, "_done_pulse"}, {30'd0, done_o, busy_o}, 32'd0);
        chk({name, "_strobe_idle"}, {29'd0, cen_o, wen_o, oen_o}, 32'd7);
    endtask

    task automatic run_vec(input int idx);
        vec_t v = vt[idx];
        int total = v.n1 + v.n2;
        int bad = 0;
        string nm = $sformatf("vec%0d", idx);
        wq.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk({nm, "_busy"}, 32'(busy_o), 32'd1);
        for (int i = 0; i < total; i++) begin
            if (i < v.n1) drive_chunk(v.num1, v.dat1, v.flush_last && (i == total - 1));
            else          drive_chunk(v.num2, v.dat2, v.flush_last && (i == total - 1));
        end
        if (!v.flush_last || total == 0) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
        end
        wait_done(nm, 9'(v.exp_n), v.exp_ovf);
        chk({nm, "_nwrites"}, 32'(wq.size()), 32'(v.exp_n));
        foreach (wq[i]) if (wq[i][23:16] != 8'(i)) bad++;
        chk({nm, "_addr_seq"}, 32'(bad), 32'd0);
        if (wq.size() > 0 && v.exp_n > 0) begin
            chk({nm, "_first"}, 32'(wq[0][15:0]), 32'(v.exp_first));
            chk({nm, "_last"}, 32'(wq[wq.size()-1][15:0]), 32'(v.exp_last));
        end
    endtask

    initial begin
`ifdef CABAC_BS_RBSP_TRAIL_EN
        vt[0] = '{1, 4'd8, 8'hA5, 1, 4'd8, 8'h3C, 1'b0, 2, 16'hA53C, 16'h8000, 1'b0};
        vt[1] = '{1, 4'd3, 8'h05, 0, 4'd0, 8'h00, 1'b0, 1, 16'hB000, 16'hB000, 1'b0};
        vt[2] = '{32, 4'd8, 8'hFF, 1, 4'd1, 8'h00, 1'b0, 17, 16'hFFFF, 16'h4000, 1'b0};
        vt[4] = '{2, 4'd6, 8'h3F, 1, 4'd5, 8'h1F, 1'b1, 2, 16'hFFFF, 16'hC000, 1'b0};
        vt[5] = '{3, 4'd0, 8'hFF, 2, 4'd8, 8'h34, 1'b0, 2, 16'h3434, 16'h8000, 1'b0};
        vt[6] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1'b0, 1, 16'h8000, 16'h8000, 1'b0};
        vt[7] = '{4, 4'd4, 8'hF3, 0, 4'd0, 8'h00, 1'b0, 2, 16'h3333, 16'h8000, 1'b0};
`else
        vt[0] = '{1, 4'd8, 8'hA5, 1, 4'd8, 8'h3C, 1'b0, 1, 16'hA53C, 16'hA53C, 1'b0};
        vt[1] = '{1, 4'd3, 8'h05, 0, 4'd0, 8'h00, 1'b0, 1, 16'hA000, 16'hA000, 1'b0};
        vt[2] = '{32, 4'd8, 8'hFF, 1, 4'd1, 8'h00, 1'b0, 17, 16'hFFFF, 16'h0000, 1'b0};
        vt[4] = '{2, 4'd6, 8'h3F, 1, 4'd5, 8'h1F, 1'b1, 2, 16'hFFFF, 16'h8000, 1'b0};
        vt[5] = '{3, 4'd0, 8'hFF, 2, 4'd8, 8'h34, 1'b0, 1, 16'h3434, 16'h3434, 1'b0};
        vt[6] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1'b0, 0, 16'h0000, 16'h0000, 1'b0};
        vt[7] = '{4, 4'd4, 8'hF3, 0, 4'd0, 8'h00, 1'b0, 1, 16'h3333, 16'h3333, 1'b0};
`endif
        vt[3] = '{514, 4'd8, 8'h11, 0, 4'd0, 8'h00, 1'b0, 256, 16'h1111, 16'h1111, 1'b1};

        rst = 1'b1; start_i = 1'b0; bits_val_i = 1'b0; flush_i = 1'b0;
        bits_num_i = '0; bits_dat_i = '0;
        #12;
        chk("rst_ctrl", {28'd0, busy_o, done_o, ovf_o, 1'b0}, 32'd0);
        chk("rst_strobe", {29'd0, cen_o, wen_o, oen_o}, 32'd7);
        chk("rst_addr_data", {addr_o, data_o}, 32'd0);
        chk("rst_word_cnt", 32'(word_cnt_o), 32'd0);
        tick();
        rst = 1'b0;

        // Reset lands while a write strobe is on the SRAM port.
        start_i = 1'b1; tick(); start_i = 1'b0;
        drive_chunk(4'd8, 8'hFF, 1'b0);
        drive_chunk(4'd4, 8'h0F, 1'b0);
        drive_chunk(4'd4, 8'h0F, 1'b0);
        chk("pre_rst_strobe", {30'd0, cen_o, wen_o}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_strobe", {29'd0, cen_o, wen_o, oen_o}, 32'd7);
        chk("mid_rst_ctrl", {29'd0, busy_o, done_o, ovf_o}, 32'd0);
        chk("mid_rst_regs", {7'd0, word_cnt_o, addr_o, data_o[7:0]}, 32'd0);
        tick();
        rst = 1'b0;
        wq.delete();
        for (int i = 0; i < 4; i++) drive_chunk(4'd8, 8'hFF, 1'b0);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        tick();
        chk("post_rst_no_strobe", 32'(wq.size()), 32'd0);
        chk("post_rst_idle", 32'(busy_o), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Restart mid-slice discards partial bits and rewinds the address.
        wq.delete();
        start_i = 1'b1; tick(); start_i = 1'b0;
        drive_chunk(4'd8, 8'hAA, 1'b0);
        start_i = 1'b1; tick(); start_i = 1'b0;
        drive_chunk(4'd8, 8'h12, 1'b0);
        chk("restart_no_early_write", {30'd0, cen_o, wen_o}, 32'd3);
        drive_chunk(4'd8, 8'h34, 1'b0);
        chk("restart_strobe", {14'd0, cen_o, wen_o, addr_o, 8'd0}, 32'd0);
        chk("restart_data", 32'(data_o), 32'h1234);
        chk("restart_cnt_live", 32'(word_cnt_o), 32'd1);
        tick();
        chk("restart_strobe_release", {30'd0, cen_o, wen_o}, 32'd3);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
`ifdef CABAC_BS_RBSP_TRAIL_EN
        wait_done("restart", 9'd2, 1'b0);
`else
        wait_done("restart", 9'd1, 1'b0);
`endif
        chk("restart_first", 32'(wq[0]), 32'h001234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cabac_bs_pack.md
Name: cabac_bs_pack

Overview:
- Upstream neighbour of the CABAC 16x256 single-port bitstream SRAM.
- Takes variable-length bit chunks (1–8 bits/cycle) from the CABAC binary arithmetic coder output stage and packs them MSB-first into 16-bit words.
- Writes each word through the SRAM's cen/oen/wen/addr/data port.
- At end of slice, flushes the partial word, then reports the word count to the bitstream output stage.

Parameters:
- WORD_W, 16, SRAM word width in bits
- ADDR_W, 8, SRAM address width; capacity is 2^ADDR_W words
- BIN_W, 8, maximum bits accepted per cycle

Ports:
- clk  input  1  clock; all logic rising-edge
- rst  input  1  asynchronous active-high reset
- start_i  input  1  pulse; begins a new slice, clears address/accumulator
- bits_val_i  input  1  chunk valid
- bits_num_i  input  4  chunk length, 1..BIN_W; 0 is treated as no-op
- bits_dat_i  input  BIN_W  chunk bits, right-aligned; bit [bits_num_i-1] is sent first
- flush_i  input  1  pulse; end of slice
- busy_o  output  1  high from start_i until done_o
- done_o  output  1  one-cycle pulse after final word written
- word_cnt_o  output  ADDR_W+1  words written this slice; valid when done_o
- ovf_o  output  1  sticky; a word was dropped because SRAM was full
- cen_o  output  1  SRAM chip enable, active low
- oen_o  output  1  SRAM output enable, active low; tied high (1)
- wen_o  output  1  SRAM write enable, active low
- addr_o  output  ADDR_W  SRAM address
- data_o  output  WORD_W  SRAM write data

Behaviour:
- Reset values:
  - busy_o=0, done_o=0, word_cnt_o=0, ovf_o=0
  - cen_o=1, wen_o=1, oen_o=1
  - addr_o=0, data_o=0
  - state=IDLE, accumulator=0, bit count=0
- States:
  - IDLE: start_i -> RUN
  - RUN: flush_i -> FLUSH
  - FLUSH: one cycle; pad and write the partial word if required -> DONE
  - DONE: one cycle; assert done_o -> IDLE
- start_i in any state:
  - Restarts: state=RUN, address=0, count=0, ovf_o=0, accumulator cleared.
  - Any write already registered for the current cycle still completes.
- Accumulator is WORD_W+BIN_W bits with fill count cnt (0..WORD_W-1 between cycles).
- On bits_val_i in RUN: acc = (acc << num) | (dat & mask), cnt += num.
- If the new cnt >= WORD_W:
  - The top WORD_W bits go to data_o.
  - Write strobe registered in the same edge: next cycle cen_o=0, wen_o=0, addr_o=current address.
  - Address increments, cnt -= WORD_W.
  - At most one word per cycle, so there is no back-pressure and no ready signal.
- Write latency: the chunk completing a word is accepted at edge N; the SRAM write strobe is visible during cycle N+1 and is sampled by the SRAM at edge N+1.
- cen_o/wen_o return high the cycle after each write; no-write cycles hold cen_o=1.
- Full:
  - When word count reaches 2^ADDR_W, further completed words are dropped: no strobe, ovf_o set, count saturates.
  - addr_o never wraps.
- flush_i together with bits_val_i in the same cycle: the chunk is accepted first, then flushed.
- bits_val_i outside RUN is ignored.
- flush_i outside RUN is ignored.
- FLUSH with cnt>0: remaining bits left-justified, zero-padded to WORD_W, written, count++.
- FLUSH with cnt=0: no write (see Optional Feature).
- word_cnt_o updates with every write; its value is final when done_o pulses.

Optional Feature:
- Macro: CABAC_BS_RBSP_TRAIL_EN.
- Defined: FLUSH first appends a single '1' (rbsp_stop_one_bit), then zero-pads to the word boundary. If cnt=0 at flush, the word written is 16'h8000.
- Undefined: zero-pad only; no write when cnt=0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/RUN/FLUSH/DONE)
  - WORD_W/ADDR_W/BIN_W defaults
  - SRAM strobe polarity constants (CEN_ON=0, WEN_ON=0)
- One natural sub-module, cabac_bs_shifter: combinational accumulator merge plus word extraction (acc, cnt, chunk -> new acc, new cnt, word, word_vld).
- FSM and SRAM strobe generation stay in cabac_bs_pack.

Test Plan:
- Reset mid-RUN after 3 chunks -> all outputs return to reset values immediately; no SRAM strobe afterwards.
- start, then chunks (8,8'hA5),(8,8'h3C), flush -> one write addr 0 data 16'hA53C; done_o pulses; word_cnt_o=1; no pad write.
- start, then 3-bit chunk 3'b101, flush -> write 16'hA000 without the macro, 16'hB000 with the macro; word_cnt_o=1.
- start, then 32 chunks of (8,8'hFF) followed by 1 chunk (1,1'b0), flush -> writes addrs 0..15 each 16'hFFFF, then 16'h0000 at addr 16; word_cnt_o=17.
- start, then 514 chunks of (8,8'h11) -> 256 writes at addrs 0..255; ovf_o=1 after word 257; addr_o never wraps; word_cnt_o=256.
- flush_i with bits_val_i (5,5'b11111) after cnt=12 -> word written with those bits; remainder 1 bit padded into the next word; word_cnt_o=2.
